// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined ID-stage control decoder with ID/EX, EX/MEM, MEM/WB control registers
module pipe_ctrl_unit #(
    parameter int             OP_W      = 6,
    parameter logic [5:0]     MUL_FUNCT = 6'b011000,
    parameter int             MUL_LAT   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [5:0]      funct_i,
    input  logic            hazard_stall_i,
    input  logic            flush_i,
    output logic            branch_o,
    output logic            jump_o,
    output logic            stall_o,
    output logic [7:0]      idex_ctrl_o,
    output logic            idex_mul_o,
    output logic [3:0]      exmem_ctrl_o,
    output logic [1:0]      memwb_ctrl_o,
    output logic            illegal_o
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    // A 1-cycle multiplier never needs the BUSY state, so the counter
    // still gets one bit to stay a legal vector.
    localparam int   CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int   CNT_INIT  = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic MUL_MULTI = (MUL_LAT > 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [7:0]         idex_next;
    logic               mul_next;
    logic [3:0]         exmem_next;
    logic [1:0]         memwb_next;
    logic               illegal_next;

    logic [7:0]         dec_word;
    logic               dec_mul;
    logic               dec_illegal;
    logic               load_bubble;
    logic               do_load;

    // Opcode/funct decode into the 8-bit control word.
    always_comb begin
        dec_word    = 8'h00;
        dec_mul     = 1'b0;
        dec_illegal = 1'b0;
        case (op_i)
            OP_R: begin
                dec_word = 8'h4E;
                dec_mul  = (funct_i == MUL_FUNCT);
            end
            OP_ADDI: dec_word = 8'h41;
            OP_LW:   dec_word = 8'hD1;
            OP_SW:   dec_word = 8'h21;
            OP_BEQ:  dec_word = 8'h02;
            OP_J:    dec_word = 8'h00;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Combinational ID-stage outputs; branch/jump are suppressed while EX is frozen.
    always_comb begin
        stall_o     = (state == BUSY);
        branch_o    = valid_i && !stall_o && (op_i == OP_BEQ);
        jump_o      = valid_i && !stall_o && (op_i == OP_J);
        load_bubble = !valid_i || flush_i || hazard_stall_i || dec_illegal;
    end

    // Next-state and next-register logic. The final BUSY edge (cnt==0) is a
    // normal load edge so the MUL spends exactly MUL_LAT cycles in EX.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idex_next    = idex_ctrl_o;
        mul_next     = idex_mul_o;
        exmem_next   = 4'h0;
        memwb_next   = exmem_ctrl_o[3:2];
        illegal_next = 1'b0;
        do_load      = 1'b0;
        case (state)
            IDLE: begin
                if (idex_mul_o && MUL_MULTI) begin
                    state_next   = BUSY;
                    cnt_next     = CNT_W'(CNT_INIT);
                    illegal_next = valid_i && !flush_i && dec_illegal;
                end else begin
                    do_load = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    do_load    = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (do_load) begin
            idex_next    = load_bubble ? 8'h00 : dec_word;
            mul_next     = load_bubble ? 1'b0 : dec_mul;
            exmem_next   = idex_ctrl_o[7:4];
            illegal_next = valid_i && !flush_i && dec_illegal;
        end
    end

    // State, counter and pipeline control registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            idex_ctrl_o  <= 8'h00;
            idex_mul_o   <= 1'b0;
            exmem_ctrl_o <= 4'h0;
            memwb_ctrl_o <= 2'b00;
            illegal_o    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idex_ctrl_o  <= idex_next;
            idex_mul_o   <= mul_next;
            exmem_ctrl_o <= exmem_next;
            memwb_ctrl_o <= memwb_next;
            illegal_o    <= illegal_next;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - scoreboard bench for pipe_ctrl_unit (MUL_LAT=4 and MUL_LAT=1 builds)
module tb_pipe_ctrl_unit;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] ADDF = 6'b100000;
    localparam logic [5:0] MULF = 6'b011000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       haz = 1'b0;
    logic       flush = 1'b0;

    logic       br4, jp4, st4, mul4, ill4;
    logic [7:0] idex4;
    logic [3:0] exmem4;
    logic [1:0] memwb4;
    logic       br1, jp1, st1, mul1, ill1;
    logic [7:0] idex1;
    logic [3:0] exmem1;
    logic [1:0] memwb1;

    pipe_ctrl_unit #(.OP_W(6), .MUL_FUNCT(6'b011000), .MUL_LAT(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct_i(funct),
        .hazard_stall_i(haz), .flush_i(flush),
        .branch_o(br4), .jump_o(jp4), .stall_o(st4),
        .idex_ctrl_o(idex4), .idex_mul_o(mul4), .exmem_ctrl_o(exmem4),
        .memwb_ctrl_o(memwb4), .illegal_o(ill4)
    );

    pipe_ctrl_unit #(.OP_W(6), .MUL_FUNCT(6'b011000), .MUL_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op), .funct_i(funct),
        .hazard_stall_i(haz), .flush_i(flush),
        .branch_o(br1), .jump_o(jp1), .stall_o(st1),
        .idex_ctrl_o(idex1), .idex_mul_o(mul1), .exmem_ctrl_o(exmem1),
        .memwb_ctrl_o(memwb1), .illegal_o(ill1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          sel1;
        logic [18:0] vec;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compares the observed outputs against the expected entry for this cycle.
    always @(negedge clk) begin
        logic [18:0] act;
        exp_t e;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            if (e.cyc < cyc) begin
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                if (e.sel1)
                    act = {idex1, mul1, exmem1, memwb1, ill1, st1, br1, jp1};
                else
                    act = {idex4, mul4, exmem4, memwb4, ill4, st4, br4, jp4};
                if (act !== e.vec) begin
                    errors = errors + 1;
                    $display("FAIL %s: got idex=%h mul=%b exmem=%h memwb=%b ill=%b stall=%b br=%b jp=%b, want idex=%h mul=%b exmem=%h memwb=%b ill=%b stall=%b br=%b jp=%b",
                             e.name, act[18:11], act[10], act[9:6], act[5:4], act[3], act[2], act[1], act[0],
                             e.vec[18:11], e.vec[10], e.vec[9:6], e.vec[5:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
                end
            end
        end
    end

    // Drive inputs for the next edge and push the expected view of the current cycle.
    task automatic row(input string nm, input bit s1,
                       input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic hz, input logic fl, input logic rs,
                       input logic [7:0] ei, input logic em, input logic [3:0] ee,
                       input logic [1:0] ew, input logic el, input logic es,
                       input logic eb, input logic ej);
        exp_t e;
        valid = v; op = o; funct = f; haz = hz; flush = fl; rst = rs;
        e.cyc  = cyc;
        e.sel1 = s1;
        e.vec  = {ei, em, ee, ew, el, es, eb, ej};
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        //   name          s1 v  op    fn    hz fl rs  idex  m  exm   mwb   il st br jp
        row("rst_a",       0, 0, LW,   ADDF, 0, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("rst_b",       0, 0, LW,   ADDF, 0, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        // T2: lw, R, sw through the pipe
        row("t2_lw",       0, 1, LW,   ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t2_r",        0, 1, R,    ADDF, 0, 0, 1, 8'hD1, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t2_sw",       0, 1, SW,   ADDF, 0, 0, 1, 8'h4E, 0, 4'hD, 2'd0, 0, 0, 0, 0);
        row("t2_e3",       0, 0, R,    ADDF, 0, 0, 1, 8'h21, 0, 4'h4, 2'd3, 0, 0, 0, 0);
        row("t2_e4",       0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h2, 2'd1, 0, 0, 0, 0);
        row("t2_e5",       0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        // T3: MUL (4 cycles in EX) followed by addi
        row("t3_mul",      0, 1, R,    MULF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t3_mul_ex",   0, 1, ADDI, ADDF, 0, 0, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t3_busy1",    0, 1, BEQ,  ADDF, 0, 0, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 1, 0, 0);
        row("t3_busy2",    0, 1, ADDI, ADDF, 1, 1, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 1, 0, 0);
        row("t3_busy3",    0, 1, ADDI, ADDF, 0, 0, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 1, 0, 0);
        row("t3_addi_ex",  0, 0, R,    ADDF, 0, 0, 1, 8'h41, 0, 4'h4, 2'd0, 0, 0, 0, 0);
        row("t3_drain1",   0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h4, 2'd1, 0, 0, 0, 0);
        row("t3_drain2",   0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd1, 0, 0, 0, 0);
        row("t3_drain3",   0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        // T4: hazard stall, retry, flush of beq, jump
        row("t4_lw_haz",   0, 1, LW,   ADDF, 1, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t4_lw_retry", 0, 1, LW,   ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t4_beq_fl",   0, 1, BEQ,  ADDF, 0, 1, 1, 8'hD1, 0, 4'h0, 2'd0, 0, 0, 1, 0);
        row("t4_j",        0, 1, JMP,  ADDF, 0, 0, 1, 8'h00, 0, 4'hD, 2'd0, 0, 0, 0, 1);
        row("t4_beq",      0, 1, BEQ,  ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd3, 0, 0, 1, 0);
        row("t4_beq_ex",   0, 0, R,    ADDF, 0, 0, 1, 8'h02, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        // T5: illegal opcode pulse, suppressed when invalid or flushed
        row("t5_bad",      0, 1, BAD,  ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t5_pulse",    0, 0, BAD,  ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 1, 0, 0, 0);
        row("t5_no_inval", 0, 1, BAD,  ADDF, 0, 1, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t5_no_flush", 0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        // T1: asynchronous reset in the middle of a MUL stall
        row("t1_mul",      0, 1, R,    MULF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t1_mul_ex",   0, 1, ADDI, ADDF, 0, 0, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t1_busy",     0, 1, ADDI, ADDF, 0, 0, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 1, 0, 0);
        row("t1_rst",      0, 1, ADDI, ADDF, 0, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t1_rst_hold", 0, 1, LW,   ADDF, 0, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t1_lw",       0, 1, LW,   ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t1_lw_idex",  0, 0, R,    ADDF, 0, 0, 1, 8'hD1, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t1_lw_exmem", 0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'hD, 2'd0, 0, 0, 0, 0);
        row("t1_lw_memwb", 0, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd3, 0, 0, 0, 0);
        // T6: MUL_LAT=1 build, MUL never stalls
        row("t6_mul",      1, 1, R,    MULF, 0, 0, 1, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t6_mul_ex",   1, 1, ADDI, ADDF, 0, 0, 1, 8'h4E, 1, 4'h0, 2'd0, 0, 0, 0, 0);
        row("t6_addi_ex",  1, 0, R,    ADDF, 0, 0, 1, 8'h41, 0, 4'h4, 2'd0, 0, 0, 0, 0);
        row("t6_drain",    1, 0, R,    ADDF, 0, 0, 1, 8'h00, 0, 4'h4, 2'd1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, %0d checks, %0d errors", checks, errors);
            $fatal(1);
        end
    end

endmodule
